// File: rtl/pdh_adc_decimator_if.sv
// AXI-Stream link carrying packed {chB,chA} block averages toward pdh_core.
// There is deliberately no tready: the consumer always accepts.
interface pdh_adc_decimator_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;

    modport master (output tdata, output tvalid);
    modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/pdh_adc_decimator.sv
// Conditions two raw ADC channels and block-averages them by 2^N.
// Emits one packed {avgB, avgA} stream beat per completed block.
module pdh_adc_decimator #(
    parameter int ADC_WIDTH       = 14,
    parameter int OUT_WIDTH       = 16,
    parameter int MAX_LOG2        = 10,
    parameter int INVERT          = 1,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [ADC_WIDTH-1:0] adc_dat_a_i,
    input  logic signed [ADC_WIDTH-1:0] adc_dat_b_i,
    input  logic                        en_i,
    input  logic [3:0]                  dec_log2_i,
    pdh_adc_decimator_if.master         m_axis,
    output logic [FRAME_CNT_WIDTH-1:0]  frame_cnt_o
);

    localparam int ACC_WIDTH = ADC_WIDTH + MAX_LOG2;
    localparam logic signed [ADC_WIDTH:0] S_MAX = (ADC_WIDTH+1)'((2**(ADC_WIDTH-1)) - 1);
    localparam logic signed [ADC_WIDTH:0] S_MIN = (ADC_WIDTH+1)'(-(2**(ADC_WIDTH-1)));
    localparam logic [3:0] N_MAX = 4'(MAX_LOG2);

    // Negating the most negative code would overflow, so it saturates to full-scale positive.
    function automatic logic signed [ADC_WIDTH-1:0] condition(input logic signed [ADC_WIDTH-1:0] raw);
        logic signed [ADC_WIDTH:0] ext;
        ext = {raw[ADC_WIDTH-1], raw};
        if (INVERT != 0) ext = -ext;
        if (ext > S_MAX)      ext = S_MAX;
        else if (ext < S_MIN) ext = S_MIN;
        return ADC_WIDTH'(ext);
    endfunction

    function automatic logic [OUT_WIDTH-1:0] average(input logic signed [ACC_WIDTH-1:0] sum,
                                                     input logic [3:0] n);
        logic signed [ADC_WIDTH-1:0] avg;
        avg = ADC_WIDTH'(sum >>> n);
        return OUT_WIDTH'(avg);
    endfunction

    logic signed [ADC_WIDTH-1:0]  s_a_q, s_a_d, s_b_q, s_b_d;
    logic                         v1_q, v1_d;
    logic [3:0]                   n_q, n_d;
    logic [MAX_LOG2-1:0]          cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0]  acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic [2*OUT_WIDTH-1:0]       tdata_q, tdata_d;
    logic                         tvalid_q, tvalid_d;
    logic [FRAME_CNT_WIDTH-1:0]   frame_q, frame_d;

    logic [3:0]                   decClamp;
    logic [MAX_LOG2-1:0]          lastCnt;
    logic                         blockEnd;
    logic signed [ACC_WIDTH-1:0]  extA, extB, sumA, sumB;

    assign decClamp = (dec_log2_i > N_MAX) ? N_MAX : dec_log2_i;
    assign lastCnt  = ~({MAX_LOG2{1'b1}} << n_q);
    assign blockEnd = v1_q && (cnt_q == lastCnt);
    assign extA     = ACC_WIDTH'(s_a_q);
    assign extB     = ACC_WIDTH'(s_b_q);
    // The first sample of a block replaces the stale accumulator instead of adding to it.
    assign sumA     = (cnt_q == '0) ? extA : acc_a_q + extA;
    assign sumB     = (cnt_q == '0) ? extB : acc_b_q + extB;

    always_comb begin
        s_a_d    = s_a_q;
        s_b_d    = s_b_q;
        v1_d     = en_i;
        n_d      = n_q;
        cnt_d    = cnt_q;
        acc_a_d  = acc_a_q;
        acc_b_d  = acc_b_q;
        tdata_d  = tdata_q;
        tvalid_d = 1'b0;
        frame_d  = frame_q;

        if (en_i) begin
            s_a_d = condition(adc_dat_a_i);
            s_b_d = condition(adc_dat_b_i);
        end

        // A decimation change or a gap in valid samples abandons the partial block.
        if (decClamp != n_q) begin
            n_d   = decClamp;
            cnt_d = '0;
        end else if (v1_q) begin
            acc_a_d = sumA;
            acc_b_d = sumB;
            cnt_d   = blockEnd ? '0 : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end

        if (blockEnd) begin
            tdata_d  = {average(sumB, n_q), average(sumA, n_q)};
            tvalid_d = 1'b1;
            frame_d  = frame_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_a_q    <= '0;
            s_b_q    <= '0;
            v1_q     <= 1'b0;
            n_q      <= '0;
            cnt_q    <= '0;
            acc_a_q  <= '0;
            acc_b_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            frame_q  <= '0;
        end else begin
            s_a_q    <= s_a_d;
            s_b_q    <= s_b_d;
            v1_q     <= v1_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            acc_a_q  <= acc_a_d;
            acc_b_q  <= acc_b_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            frame_q  <= frame_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign frame_cnt_o   = frame_q;

endmodule
